// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage store buffer: access sizes, the
// buffered payload type and the lane helpers used by both the store
// and load paths. Lanes are big-endian: byte offset 0 is bits [31:24],
// and lane mask bit i covers bits [8*i+7:8*i].
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_payload_t;

  // Half accesses need an even byte offset; word accesses (10 or 11) need offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Lanes touched by an aligned access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    case (size)
      SZ_BYTE: m = 4'b1000 >> off;
      SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Move right-aligned store data into the lanes selected by size/offset.
  function automatic logic [31:0] lane_shift(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] data);
    logic [31:0] r;
    r = data;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r = {data[7:0], 24'h0};
          2'd1:    r = {8'h0, data[7:0], 16'h0};
          2'd2:    r = {16'h0, data[7:0], 8'h0};
          default: r = {24'h0, data[7:0]};
        endcase
      end
      SZ_HALF: r = off[1] ? {16'h0, data[15:0]} : {data[15:0], 16'h0};
      default: r = data;
    endcase
    return r;
  endfunction

  // Take masked lanes from the new data and the rest from the old word.
  function automatic logic [31:0] merge(input logic [31:0] new_data, input logic [31:0] old_data,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_data;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_data[8*i +: 8];
    end
    return r;
  endfunction

  // Pick the addressed byte/half out of a memory word and zero/sign extend it.
  function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular storage for buffered stores. Only the valid bits and pointers
// are reset; payload storage is written on push and read at the head.
// A per-entry compare vector lets the top detect loads that collide
// with any pending store word.
module sb_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_waddr,
  input  sb_payload_t                push_payload,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [AW-1:0]              head_waddr,
  output sb_payload_t                head_payload,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [AW-1:0]              cmp_waddr,
  output logic [DEPTH-1:0]           cmp_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    waddr_q   [DEPTH];
  sb_payload_t      payload_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == CW'(DEPTH));
  assign push_ok    = push && !full;
  assign head_valid = valid[rd_ptr];
  assign pop_ok     = pop && head_valid;
  assign head_waddr   = waddr_q[rd_ptr];
  assign head_payload = payload_q[rd_ptr];

  // Pointer, occupancy and valid-bit bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload capture; contents of invalid entries are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      waddr_q[wr_ptr]   <= push_waddr;
      payload_q[wr_ptr] <= push_payload;
    end
  end

  // Word-address match against every valid entry, lane mask deliberately ignored.
  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp_hit[i] = valid[i] && (waddr_q[i] == cmp_waddr);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer. Stores are lane-shifted and queued; the head
// drains one per cycle. Full-word heads write blindly, sub-word heads
// need dm's single async read port for a read-modify-write, which they
// share with loads. A starve counter lets a blocked sub-word drain steal
// the port from a load after STARVE_LIMIT cycles. Loads stall on any
// pending store to the same word; there is no forwarding.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int AW           = 7,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [1:0]                 st_size,
  input  logic [31:0]                st_data,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  input  logic [1:0]                 ld_size,
  input  logic                       ld_signed,
  output logic [31:0]                ld_data,
  output logic                       ld_stall,
  output logic                       align_err,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH+1)-1:0] sb_count,
  output logic [AW-1:0]              dm_raddr,
  input  logic [31:0]                dm_rdata,
  output logic [AW-1:0]              dm_waddr,
  output logic                       dm_wr,
  output logic [31:0]                dm_wdata
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  logic [AW-1:0]    st_waddr;
  logic [AW-1:0]    ld_waddr;
  logic             st_mis;
  logic             ld_mis;
  logic             ld_active;
  logic             push;
  sb_payload_t      push_payload;
  logic             head_valid;
  logic [AW-1:0]    head_waddr;
  sb_payload_t      head_payload;
  logic             head_full;
  logic [DEPTH-1:0] hit_vec;
  logic             hit;
  logic             steal;
  logic             load_owns;
  logic             drain;
  logic             blocked;
  logic [SW-1:0]    starve;
  logic             unused_addr_bits;

  // Only the word-address bits reach dm; the upper address bits are ignored.
  assign st_waddr         = st_addr[AW+1:2];
  assign ld_waddr         = ld_addr[AW+1:2];
  assign unused_addr_bits = ^{st_addr[31:AW+2], ld_addr[31:AW+2]};

  assign st_mis = is_misaligned(st_size, st_addr[1:0]);
  assign ld_mis = is_misaligned(ld_size, ld_addr[1:0]);

  // A misaligned load returns zero without stalling, so it never contends for the read port.
  assign ld_active = ld_valid && !ld_mis;

  assign st_ready = (sb_count < CW'(DEPTH));
  assign sb_empty = (sb_count == '0);
  assign push     = st_valid && st_ready && !st_mis;

  // Build the lane-aligned payload for an incoming store.
  always_comb begin
    push_payload      = '0;
    push_payload.mask = lane_mask(st_size, st_addr[1:0]);
    push_payload.data = lane_shift(st_size, st_addr[1:0], st_data);
  end

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_waddr   (st_waddr),
    .push_payload (push_payload),
    .pop          (drain),
    .head_valid   (head_valid),
    .head_waddr   (head_waddr),
    .head_payload (head_payload),
    .count        (sb_count),
    .cmp_waddr    (ld_waddr),
    .cmp_hit      (hit_vec)
  );

  // Read-port arbitration: the load keeps the port unless it is stalled, either by a
  // word collision or because a starved sub-word drain has claimed the port.
  assign head_full = (head_payload.mask == 4'b1111);
  assign hit       = |hit_vec;
  assign steal     = (starve == SW'(STARVE_LIMIT));
  assign ld_stall  = ld_active && (hit || steal);
  assign load_owns = ld_active && !ld_stall;
  assign drain     = head_valid && (head_full || !load_owns);
  assign blocked   = head_valid && !head_full && load_owns;

  // The read port points at the head word only while a sub-word drain actually needs it.
  assign dm_raddr = (head_valid && !head_full && !load_owns) ? head_waddr : ld_waddr;

  assign dm_wr    = drain;
  assign dm_waddr = head_waddr;
  assign dm_wdata = merge(head_payload.data, dm_rdata, head_payload.mask);

  assign ld_data = ld_mis ? 32'h0 : ld_extract(dm_rdata, ld_size, ld_addr[1:0], ld_signed);

  // Count cycles a sub-word head loses the port; any drain clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (drain) begin
      starve <= '0;
    end else if (blocked) begin
      starve <= starve + 1'b1;
    end
  end

  // One-cycle registered flag for a misaligned store or load request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
    end else begin
      align_err <= (st_valid && st_mis) || (ld_valid && ld_mis);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: a behavioural dm model, a write/load
// scoreboard checked by a negedge monitor, and directed store/load
// sequences with hand-computed expected values.
module tb_store_buffer;
  import mips_mem_pkg::*;

  typedef struct packed {
    logic [6:0]  waddr;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        align_err;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic [6:0]  dm_raddr;
  logic [31:0] dm_rdata;
  logic [6:0]  dm_waddr;
  logic        dm_wr;
  logic [31:0] dm_wdata;

  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [31:0] pre_data;

  wr_exp_t     wr_q [$];
  logic [31:0] ld_q [$];

  int errors;
  int checks;
  int stall_seen;
  int nr_total;
  int nr_count;

  store_buffer #(
    .DEPTH        (4),
    .AW           (7),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_size   (st_size),
    .st_data   (st_data),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_size   (ld_size),
    .ld_signed (ld_signed),
    .ld_data   (ld_data),
    .ld_stall  (ld_stall),
    .align_err (align_err),
    .sb_empty  (sb_empty),
    .sb_count  (sb_count),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .dm_waddr  (dm_waddr),
    .dm_wr     (dm_wr),
    .dm_wdata  (dm_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: async read, synchronous write, plus a preload port for setup.
  assign dm_rdata = mem[dm_raddr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (dm_wr) mem[dm_waddr] <= dm_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every dm write must match the next expected write; every unstalled
  // load with an outstanding expectation is compared against it.
  wr_exp_t mon_wr;
  logic [31:0] mon_ld;
  always @(negedge clk) begin
    if (dm_wr) begin
      if (wr_q.size() == 0) begin
        check_output("unexpected dm_wr", 32'(dm_wr), 32'h0);
      end else begin
        mon_wr = wr_q.pop_front();
        check_output("dm_waddr", 32'(dm_waddr), 32'(mon_wr.waddr));
        check_output("dm_wdata", dm_wdata, mon_wr.data);
      end
    end
    if (ld_valid && !ld_stall && ld_q.size() > 0) begin
      mon_ld = ld_q.pop_front();
      check_output("ld_data", ld_data, mon_ld);
    end
  end

  task automatic preload(input logic [6:0] addr, input logic [31:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // Present one store and hold it until accepted; optionally register the expected dm write.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                                input bit expect_wr, input logic [31:0] exp_data);
    bit      accepted;
    bit      rdy;
    wr_exp_t e;
    accepted = 1'b0;
    if (expect_wr) begin
      e.waddr = addr[8:2];
      e.data  = exp_data;
      wr_q.push_back(e);
    end
    st_valid = 1'b1;
    st_addr  = addr;
    st_size  = size;
    st_data  = data;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      rdy = st_ready;
      if (ld_stall) stall_seen++;
      if (!rdy) begin
        nr_total++;
        nr_count = int'(sb_count);
      end
      @(posedge clk);
      #1;
      accepted = rdy;
    end
    st_valid = 1'b0;
    if (!accepted) check_output("store accept timeout", 32'h0, 32'h1);
  endtask

  // Present one load, push its expected data, and hold it until the monitor has compared it.
  task automatic apply_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] expected, input int exp_stalls, input string name);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    ld_q.push_back(expected);
    ld_valid  = 1'b1;
    ld_addr   = addr;
    ld_size   = size;
    ld_signed = sgn;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (ld_stall) stalls++;
      @(posedge clk);
      #1;
      done = (ld_q.size() == 0);
    end
    ld_valid = 1'b0;
    if (!done) begin
      check_output({name, " timeout"}, 32'h0, 32'h1);
      ld_q.delete();
    end
    check_output({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    bool_wait_block: begin end
    errors = 0; checks = 0; stall_seen = 0; nr_total = 0; nr_count = 0;
    rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    st_valid = 1'b0; st_addr = '0; st_size = SZ_WORD; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = SZ_WORD; ld_signed = 1'b0;
    @(posedge clk);
    #1;
    preload(7'd0,  32'h0000CAFE);
    preload(7'd16, 32'h0BADF00D);
    preload(7'd20, 32'h12345678);
    preload(7'd21, 32'h00000003);
    preload(7'd24, 32'h11111111);
    preload(7'd25, 32'h22222222);
    preload(7'd26, 32'h33333333);

    $display("[TB] reset state");
    ld_valid = 1'b1; ld_addr = 32'h50; ld_size = SZ_WORD;
    #1;
    check_output("reset st_ready", 32'(st_ready), 32'h1);
    check_output("reset sb_empty", 32'(sb_empty), 32'h1);
    check_output("reset sb_count", 32'(sb_count), 32'h0);
    check_output("reset dm_wr", 32'(dm_wr), 32'h0);
    check_output("reset ld_stall", 32'(ld_stall), 32'h0);
    check_output("reset align_err", 32'(align_err), 32'h0);
    check_output("reset ld_data", ld_data, 32'h12345678);
    ld_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] word store drains next cycle");
    apply_stimulus(32'h50, SZ_WORD, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    check_output("sw dm_wr", 32'(dm_wr), 32'h1);
    check_output("sw sb_count", 32'(sb_count), 32'h1);
    @(posedge clk);
    #1;
    check_output("sw mem[20]", mem[20], 32'hDEADBEEF);
    check_output("sw sb_empty", 32'(sb_empty), 32'h1);

    $display("[TB] byte store read-modify-write");
    apply_stimulus(32'h55, SZ_BYTE, 32'h000000AB, 1'b1, 32'h00AB0003);
    @(posedge clk);
    #1;
    check_output("sb mem[21]", mem[21], 32'h00AB0003);

    $display("[TB] load stalls on pending store, then extract");
    apply_stimulus(32'h54, SZ_WORD, 32'h00000080, 1'b1, 32'h00000080);
    apply_load(32'h54, SZ_WORD, 1'b0, 32'h00000080, 1, "lw 0x54");
    apply_load(32'h57, SZ_BYTE, 1'b1, 32'hFFFFFF80, 0, "lb 0x57");
    apply_load(32'h57, SZ_BYTE, 1'b0, 32'h00000080, 0, "lbu 0x57");
    apply_load(32'h56, SZ_HALF, 1'b1, 32'h00000080, 0, "lh 0x56");
    apply_load(32'h50, SZ_BYTE, 1'b1, 32'hFFFFFFDE, 0, "lb 0x50");
    apply_load(32'h51, SZ_BYTE, 1'b0, 32'h000000AD, 0, "lbu 0x51");
    apply_load(32'h52, SZ_HALF, 1'b0, 32'h0000BEEF, 0, "lhu 0x52");
    apply_load(32'h50, SZ_HALF, 1'b1, 32'hFFFFDEAD, 0, "lh 0x50");

    $display("[TB] misaligned store and load");
    st_valid = 1'b1; st_addr = 32'h51; st_size = SZ_HALF; st_data = 32'h1234;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    check_output("sh 0x51 align_err", 32'(align_err), 32'h1);
    check_output("sh 0x51 sb_count", 32'(sb_count), 32'h0);
    @(posedge clk);
    #1;
    check_output("sh 0x51 align_err clears", 32'(align_err), 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h52; ld_size = SZ_WORD; ld_signed = 1'b0;
    #1;
    check_output("lw 0x52 ld_data", ld_data, 32'h0);
    check_output("lw 0x52 ld_stall", 32'(ld_stall), 32'h0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    check_output("lw 0x52 align_err", 32'(align_err), 32'h1);
    @(posedge clk);
    #1;
    check_output("lw 0x52 align_err clears", 32'(align_err), 32'h0);

    $display("[TB] starvation and steal");
    stall_seen = 0; nr_total = 0; nr_count = 0;
    ld_valid = 1'b1; ld_addr = 32'h40; ld_size = SZ_WORD; ld_signed = 1'b0;
    apply_stimulus(32'h00, SZ_HALF, 32'h1111, 1'b1, 32'h1111CAFE);
    apply_stimulus(32'h00, SZ_HALF, 32'h2222, 1'b1, 32'h2222CAFE);
    apply_stimulus(32'h00, SZ_HALF, 32'h3333, 1'b1, 32'h3333CAFE);
    apply_stimulus(32'h00, SZ_HALF, 32'h4444, 1'b1, 32'h4444CAFE);
    apply_stimulus(32'h00, SZ_HALF, 32'h5555, 1'b1, 32'h5555CAFE);
    check_output("full: not-ready cycles", 32'(nr_total), 32'h1);
    check_output("full: count when not ready", 32'(nr_count), 32'h4);
    check_output("steal: stalls during fill", 32'(stall_seen), 32'h1);
    pat = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output($sformatf("steal pattern cycle %0d", i), 32'(ld_stall), 32'(pat[i]));
      @(posedge clk);
      #1;
    end
    check_output("steal: count after second steal", 32'(sb_count), 32'h3);
    ld_valid = 1'b0;
    for (int n = 0; n < 20 && !sb_empty; n++) begin
      @(posedge clk);
      #1;
    end
    check_output("steal: drained empty", 32'(sb_empty), 32'h1);
    check_output("steal: mem[0]", mem[0], 32'h5555CAFE);

    $display("[TB] reset discards pending stores");
    ld_valid = 1'b1; ld_addr = 32'h40; ld_size = SZ_WORD;
    apply_stimulus(32'h60, SZ_HALF, 32'hAAAA, 1'b0, 32'h0);
    apply_stimulus(32'h64, SZ_HALF, 32'hBBBB, 1'b0, 32'h0);
    apply_stimulus(32'h68, SZ_HALF, 32'hCCCC, 1'b0, 32'h0);
    check_output("pre-reset sb_count", 32'(sb_count), 32'h3);
    check_output("pre-reset dm_wr", 32'(dm_wr), 32'h0);
    rst = 1'b1;
    #1;
    check_output("mid-reset dm_wr", 32'(dm_wr), 32'h0);
    check_output("mid-reset sb_count", 32'(sb_count), 32'h0);
    check_output("mid-reset st_ready", 32'(st_ready), 32'h1);
    check_output("mid-reset ld_stall", 32'(ld_stall), 32'h0);
    check_output("mid-reset ld_data", ld_data, 32'h0BADF00D);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("reset mem[24]", mem[24], 32'h11111111);
    check_output("reset mem[25]", mem[25], 32'h22222222);
    check_output("reset mem[26]", mem[26], 32'h33333333);
    check_output("pending writes", 32'(wr_q.size()), 32'h0);
    check_output("pending loads", 32'(ld_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
